decode_regfile: RTL

//  Register file and pending-write scoreboard for the decode stage. Receives

---
 rtl/decode_regfile_if.sv | 29 ++
 rtl/decode_regfile.sv | 69 ++++++
 2 files changed

// File: rtl/decode_regfile_if.sv
// Decode-side register-file bus: two read ports, issue (scoreboard set) and writeback.
// master = decode/writeback driver, slave = decode_regfile.
interface decode_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] rd_reg1;
  logic [ADDR_W-1:0] rd_reg2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              busy1;
  logic              busy2;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_reg;
  logic              wr_en;
  logic [ADDR_W-1:0] writereg;
  logic [DATA_W-1:0] regwritedata;
  logic              err;

  modport master (
    output rd_reg1, rd_reg2, issue_en, issue_reg, wr_en, writereg, regwritedata,
    input  rd_data1, rd_data2, busy1, busy2, err
  );

  modport slave (
    input  rd_reg1, rd_reg2, issue_en, issue_reg, wr_en, writereg, regwritedata,
    output rd_data1, rd_data2, busy1, busy2, err
  );
endinterface

// File: rtl/decode_regfile.sv
// Decode-stage register file with per-register pending-writer scoreboard and sticky error flag.
// Optional macro REGFILE_BYPASS_EN adds a combinational write-through bypass on both read ports.
module decode_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic             clk,
  input logic             rst,
  decode_regfile_if.slave rf
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic [NREG-1:0]   busy_nxt;
  logic              err_q;
  logic              err_hit;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (rf.issue_en) set_vec[rf.issue_reg] = 1'b1;
    if (rf.wr_en)    clr_vec[rf.writereg]  = 1'b1;
  end

  // A same-cycle issue wins over the retiring writer, so set is OR'd in last.
  assign busy_nxt = set_vec | (busy & ~clr_vec);

  // Double pending writer, or a writeback nobody was waiting for.
  assign err_hit = (|(set_vec & busy & ~clr_vec)) | (|(clr_vec & ~busy & ~set_vec));

  always_comb begin
    rf.rd_data1 = regs[rf.rd_reg1];
    rf.busy1    = busy[rf.rd_reg1];
`ifdef REGFILE_BYPASS_EN
    if (rf.wr_en && (rf.writereg == rf.rd_reg1)) begin
      rf.rd_data1 = rf.regwritedata;
      rf.busy1    = rf.issue_en && (rf.issue_reg == rf.rd_reg1);
    end
`endif
  end

  always_comb begin
    rf.rd_data2 = regs[rf.rd_reg2];
    rf.busy2    = busy[rf.rd_reg2];
`ifdef REGFILE_BYPASS_EN
    if (rf.wr_en && (rf.writereg == rf.rd_reg2)) begin
      rf.rd_data2 = rf.regwritedata;
      rf.busy2    = rf.issue_en && (rf.issue_reg == rf.rd_reg2);
    end
`endif
  end

  assign rf.err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy  <= '0;
      err_q <= 1'b0;
    end else begin
      if (rf.wr_en) regs[rf.writereg] <= rf.regwritedata;
      busy  <= busy_nxt;
      err_q <= err_q | err_hit;
    end
  end
endmodule
